// File: rtl/divsched_pkg.sv
// divsched_pkg: shared state encoding, default widths and constants for divider_scheduler.
package divsched_pkg;

    localparam int DIV_WIDTH_DEF      = 32;
    localparam int N_REQ_DEF          = 4;
    localparam int ID_W_DEF           = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    // Quotient returned on divide-by-zero; truncated to DIV_WIDTH at use.
    localparam logic [63:0] DZ_Q = '1;

    typedef enum logic [2:0] {
        ST_DRAIN     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/divsched_rr_arbiter.sv
// divsched_rr_arbiter: combinational round-robin pick of the first valid request at or after the pointer.
module divsched_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;
    logic [ID_W:0]      w_wrap;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign w_dbl = {i_req, i_req} >> i_ptr;

    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (w_dbl[k]) w_off = ID_W'(k);
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign w_wrap  = w_sum - (ID_W + 1)'(N_REQ);
    assign o_idx   = (w_sum >= (ID_W + 1)'(N_REQ)) ? w_wrap[ID_W-1:0] : w_sum[ID_W-1:0];
    assign o_any   = |i_req;
    assign o_grant = o_any ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/divider_scheduler.sv
// divider_scheduler: shares one divider among N_REQ requesters, round-robin, one operation in flight.
// Optional watchdog on the divider handshake is enabled by defining DIVSCHED_TIMEOUT_EN.
module divider_scheduler
    import divsched_pkg::*;
#(
    parameter int DIV_WIDTH      = DIV_WIDTH_DEF,
    parameter int N_REQ          = N_REQ_DEF,
    parameter int ID_W           = ID_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0]           req_sign,
    input  logic [N_REQ*DIV_WIDTH-1:0] req_a,
    input  logic [N_REQ*DIV_WIDTH-1:0] req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [DIV_WIDTH-1:0]       rsp_q,
    output logic [DIV_WIDTH-1:0]       rsp_r,
    output logic                       rsp_dz,
    output logic                       rsp_err,
    output logic                       div_start,
    output logic                       div_sign,
    output logic [DIV_WIDTH-1:0]       div_in1,
    output logic [DIV_WIDTH-1:0]       div_in2,
    input  logic [DIV_WIDTH-1:0]       div_q,
    input  logic [DIV_WIDTH-1:0]       div_r,
    input  logic                       div_ready
);

    state_t               r_state;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_id;
    logic [DIV_WIDTH-1:0] r_a;
    logic [DIV_WIDTH-1:0] r_b;
    logic                 r_sign;
    logic [DIV_WIDTH-1:0] r_q;
    logic [DIV_WIDTH-1:0] r_r;
    logic                 r_dz;

    logic [N_REQ-1:0]     w_grant;
    logic [ID_W-1:0]      w_idx;
    logic                 w_any;
    logic [DIV_WIDTH-1:0] w_a;
    logic [DIV_WIDTH-1:0] w_b;

`ifdef DIVSCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_to;
    assign w_to    = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    divsched_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_a       = req_a[int'(w_idx)*DIV_WIDTH +: DIV_WIDTH];
    assign w_b       = req_b[int'(w_idx)*DIV_WIDTH +: DIV_WIDTH];
    assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
    assign rsp_valid = r_state == ST_RESP;
    assign div_start = r_state == ST_ISSUE;
    // Operand registers feed the divider directly so they stay frozen until the response leaves.
    assign div_in1   = r_a;
    assign div_in2   = r_b;
    assign div_sign  = r_sign;
    assign rsp_id    = r_id;
    assign rsp_q     = r_q;
    assign rsp_r     = r_r;
    assign rsp_dz    = r_dz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DRAIN;
            r_ptr   <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sign  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
`ifdef DIVSCHED_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_DRAIN: if (div_ready) r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (w_any) begin
                        r_a    <= w_a;
                        r_b    <= w_b;
                        r_sign <= req_sign[w_idx];
                        r_id   <= w_idx;
                        r_ptr  <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                        if (w_b == '0) begin
                            r_q     <= DIV_WIDTH'(DZ_Q);
                            r_r     <= w_a;
                            r_dz    <= 1'b1;
`ifdef DIVSCHED_TIMEOUT_EN
                            r_err   <= 1'b0;
`endif
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
`ifdef DIVSCHED_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
`ifdef DIVSCHED_TIMEOUT_EN
                    r_cnt <= r_cnt + 1'b1;
                    if (w_to) begin
                        r_q     <= '0;
                        r_r     <= '0;
                        r_dz    <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (!div_ready) r_state <= ST_WAIT_DONE;
`else
                    if (!div_ready) r_state <= ST_WAIT_DONE;
`endif
                end
                ST_WAIT_DONE: begin
`ifdef DIVSCHED_TIMEOUT_EN
                    r_cnt <= r_cnt + 1'b1;
                    if (w_to) begin
                        r_q     <= '0;
                        r_r     <= '0;
                        r_dz    <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else if (div_ready) begin
                        r_q     <= div_q;
                        r_r     <= div_r;
                        r_dz    <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end
`else
                    if (div_ready) begin
                        r_q     <= div_q;
                        r_r     <= div_r;
                        r_dz    <= 1'b0;
                        r_state <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
`ifdef DIVSCHED_TIMEOUT_EN
                    // After a watchdog abort the divider state is unknown, so resynchronise first.
                    if (rsp_ready) r_state <= r_err ? ST_DRAIN : ST_IDLE;
`else
                    if (rsp_ready) r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_DRAIN;
            endcase
        end
    end

endmodule
